// File: rtl/bus_memory_responder.sv
// Single-port word memory answering one bus request at a time after a fixed LATENCY.
// Define BUS_MEMORY_MISALIGN_CHECK_EN to flag misaligned or illegal-size accesses via o_err.
module bus_memory_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_bus_DV,
    input  logic [31:0] i_bus_address,
    input  logic [31:0] i_bus_data,
    input  logic [2:0]  i_bhw,
    input  logic        i_write_notread,
    output logic        o_bus_DV,
    output logic [31:0] o_bus_data,
    output logic        o_err,
    output logic        o_busy
);
    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic [3:0]  CNT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [2:0]    bhw_q, bhw_d;
    logic          we_q, we_d;
    logic          bus_dv_q, bus_dv_d;
    logic [31:0]   bus_data_q, bus_data_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic [31:0]   mem_q [MEM_WORDS];

    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word, rd_data, wr_word;
    logic          size_byte, size_half, size_word, req_err, mem_we;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^i_bus_address[31:AW+2];

    always_comb begin
        word_idx  = addr_q[AW+1:2];
        rd_word   = mem_q[word_idx];
        size_byte = (bhw_q == 3'b001);
        size_half = (bhw_q == 3'b010);
        size_word = (bhw_q == 3'b100);
`ifdef BUS_MEMORY_MISALIGN_CHECK_EN
        req_err = (size_half && addr_q[0]) ||
                  (size_word && (addr_q[1:0] != 2'b00)) ||
                  !(size_byte || size_half || size_word);
`else
        req_err = 1'b0;
`endif
        rd_data = rd_word;
        wr_word = rd_word;
        if (size_byte) begin
            rd_data = {24'h0, rd_word[{addr_q[1:0], 3'b000} +: 8]};
            wr_word[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end else if (size_half) begin
            rd_data = {16'h0, rd_word[{addr_q[1], 4'b0000} +: 16]};
            wr_word[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
        end else begin
            // Any other size code (including illegal ones) behaves as a full word.
            wr_word = data_q;
        end
        mem_we = (state_q == RESPOND) && we_q && !req_err;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        bhw_d      = bhw_q;
        we_d       = we_q;
        bus_dv_d   = 1'b0;
        bus_data_d = bus_data_q;
        err_d      = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (i_bus_DV) begin
                    state_d = WAIT;
                    addr_d  = i_bus_address[AW+1:0];
                    data_d  = i_bus_data;
                    bhw_d   = i_bhw;
                    we_d    = i_write_notread;
                    busy_d  = 1'b1;
                end
            end
            WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) state_d = RESPOND;
                else                   cnt_d   = cnt_q + 4'd1;
            end
            RESPOND: begin
                // busy stays high through the cycle in which the response is visible.
                state_d  = IDLE;
                cnt_d    = '0;
                busy_d   = 1'b1;
                bus_dv_d = 1'b1;
                err_d    = req_err;
                if (req_err)    bus_data_d = '0;
                else if (!we_q) bus_data_d = rd_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            bhw_q      <= '0;
            we_q       <= 1'b0;
            bus_dv_q   <= 1'b0;
            bus_data_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            bhw_q      <= bhw_d;
            we_q       <= we_d;
            bus_dv_q   <= bus_dv_d;
            bus_data_q <= bus_data_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Memory contents survive reset; only the response edge commits writes.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem_q[word_idx] <= wr_word;
    end

    assign o_bus_DV   = bus_dv_q;
    assign o_bus_data = bus_data_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
endmodule

// File: tb/tb_bus_memory_responder.sv
// Randomized self-checking bench for bus_memory_responder against a word-array reference model.
module tb_bus_memory_responder;
    localparam int unsigned MEMW = 4096;
    localparam int unsigned LAT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_dv_in;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bhw;
    logic        wnr;
    logic        bus_dv_out;
    logic [31:0] bus_rdata;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mdl [MEMW];
    logic [31:0] last_rd;

    bus_memory_responder #(.MEM_WORDS(MEMW), .LATENCY(LAT)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_bus_DV        (bus_dv_in),
        .i_bus_address   (bus_addr),
        .i_bus_data      (bus_wdata),
        .i_bhw           (bhw),
        .i_write_notread (wnr),
        .o_bus_DV        (bus_dv_out),
        .o_bus_data      (bus_rdata),
        .o_err           (err),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit mdl_err(input logic [31:0] a, input logic [2:0] b);
`ifdef BUS_MEMORY_MISALIGN_CHECK_EN
        return (b == 3'b010 && a[0]) || (b == 3'b100 && a[1:0] != 2'b00) ||
               !(b == 3'b001 || b == 3'b010 || b == 3'b100);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: apply the access to the model and return the expected response.
    task automatic mdl_access(input logic [31:0] a, input logic [31:0] d, input logic [2:0] b,
                              input logic we, output logic [31:0] exp_d, output logic exp_e);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] w;
        logic [31:0] mask;
        idx   = (a >> 2) % MEMW;
        w     = mdl[idx];
        exp_e = mdl_err(a, b);
        if (b == 3'b001) begin
            sh = 8 * a[1:0];  mask = 32'hFF;
        end else if (b == 3'b010) begin
            sh = 16 * a[1];   mask = 32'hFFFF;
        end else begin
            sh = 0;           mask = 32'hFFFF_FFFF;
        end
        if (exp_e) begin
            exp_d   = 32'h0;
            last_rd = 32'h0;
        end else if (we) begin
            mdl[idx] = (w & ~(mask << sh)) | ((d & mask) << sh);
            exp_d    = last_rd;
        end else begin
            last_rd = (w >> sh) & mask;
            exp_d   = last_rd;
        end
    endtask

    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] b, input logic we, input bit dbl);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        int          extra;
        bit          seen;
        bit          busy_ok;
        mdl_access(a, d, b, we, exp_d, exp_e);
        bus_addr  = a;
        bus_wdata = d;
        bhw       = b;
        wnr       = we;
        bus_dv_in = 1'b1;
        @(posedge clk); #1;
        bus_dv_in = 1'b0;
        if (dbl) begin
            bus_dv_in = 1'b1;
            bus_addr  = a ^ 32'h4;
            bus_wdata = ~d;
            wnr       = 1'b1;
        end
        n = 0; seen = 1'b0; busy_ok = 1'b1;
        while (n < 40 && !seen) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
            bus_dv_in = 1'b0;
            seen = bus_dv_out;
        end
        check({tag, "/latency"}, 32'(n), 32'(LAT + 1));
        check({tag, "/busy_wait"}, {31'h0, busy_ok}, 32'h1);
        check({tag, "/busy_resp"}, {31'h0, busy}, 32'h1);
        check({tag, "/err"}, {31'h0, err}, {31'h0, exp_e});
        check({tag, "/data"}, bus_rdata, exp_d);
        if (dbl) begin
            extra = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus_dv_out) extra++;
            end
            check({tag, "/extra_dv"}, 32'(extra), 32'h0);
            check({tag, "/busy_after"}, {31'h0, busy}, 32'h0);
        end
    endtask

    initial begin
        int unsigned idx;
        int unsigned lo;
        int unsigned r;
        logic [2:0]  b;
        logic [2:0]  illegal [5];
        int          stray;
        illegal[0] = 3'b000; illegal[1] = 3'b011; illegal[2] = 3'b101;
        illegal[3] = 3'b110; illegal[4] = 3'b111;
        rst_n = 1'b0; bus_dv_in = 1'b0; bus_addr = '0; bus_wdata = '0; bhw = 3'b100; wnr = 1'b0;
        last_rd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/dv", {31'h0, bus_dv_out}, 32'h0);
        check("reset/data", bus_rdata, 32'h0);
        check("reset/err", {31'h0, err}, 32'h0);
        check("reset/busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;

        txn("wr_word_100", 32'h100, 32'hDEAD_BEEF, 3'b100, 1'b1, 1'b0);
        txn("rd_word_100", 32'h100, 32'h0, 3'b100, 1'b0, 1'b0);
        txn("wr_byte_102", 32'h102, 32'h0000_0055, 3'b001, 1'b1, 1'b0);
        txn("rd_word_100b", 32'h100, 32'h0, 3'b100, 1'b0, 1'b0);
        check("lane_merge", bus_rdata, 32'hDE55_BEEF);
        txn("rd_byte_103", 32'h103, 32'h0, 3'b001, 1'b0, 1'b0);
        check("byte_103", bus_rdata, 32'h0000_00DE);
        txn("rd_half_102", 32'h102, 32'h0, 3'b010, 1'b0, 1'b0);
        check("half_102", bus_rdata, 32'h0000_DE55);
        txn("wr_wrap_4100", 32'h4100, 32'hA5A5_A5A5, 3'b100, 1'b1, 1'b0);
        txn("rd_wrap_100", 32'h100, 32'h0, 3'b100, 1'b0, 1'b0);
        check("wrap_100", bus_rdata, 32'hA5A5_A5A5);
        txn("double_strobe", 32'h100, 32'h0, 3'b100, 1'b0, 1'b1);

        txn("wr_200_prior", 32'h200, 32'hCAFE_F00D, 3'b100, 1'b1, 1'b0);
        bus_addr = 32'h200; bus_wdata = 32'h1234_5678; bhw = 3'b100; wnr = 1'b1; bus_dv_in = 1'b1;
        @(posedge clk); #1;
        bus_dv_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst/dv", {31'h0, bus_dv_out}, 32'h0);
        check("midrst/data", bus_rdata, 32'h0);
        check("midrst/err", {31'h0, err}, 32'h0);
        check("midrst/busy", {31'h0, busy}, 32'h0);
        stray = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus_dv_out) stray++;
        end
        rst_n = 1'b1;
        last_rd = 32'h0;
        check("midrst/no_dv", 32'(stray), 32'h0);
        txn("rd_200_after_rst", 32'h200, 32'h0, 3'b100, 1'b0, 1'b0);
        check("rst_no_commit", bus_rdata, 32'hCAFE_F00D);

        txn("wr_half_201", 32'h201, 32'h0000_BEEF, 3'b010, 1'b1, 1'b0);
        txn("rd_200_after_half", 32'h200, 32'h0, 3'b100, 1'b0, 1'b0);

        for (int unsigned i = 0; i < 64; i++)
            txn("init", i << 2, $urandom, 3'b100, 1'b1, 1'b0);

        for (int k = 0; k < 200; k++) begin
            idx = $urandom_range(0, 63);
            lo  = $urandom_range(0, 3);
            r   = $urandom_range(0, 9);
            if (r < 3)      b = 3'b001;
            else if (r < 6) b = 3'b010;
            else if (r < 9) b = 3'b100;
            else            b = illegal[$urandom_range(0, 4)];
            txn("rand", ($urandom & 32'hFFFF_C000) | (idx << 2) | lo, $urandom, b,
                1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_memory_responder.md
BUS_MEMORY_RESPONDER -- requirements
Module: bus_memory_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request capture to response, legal range 1..15.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port i_bus_DV, input, 1, one-cycle request strobe from initiator.
REQ-006 SHALL have port i_bus_address, input, 32, byte address.
REQ-007 SHALL have port i_bus_data, input, 32, write data, right-aligned.
REQ-008 SHALL have port i_bhw, input, 3, size: 001 byte, 010 half, 100 word.
REQ-009 SHALL have port i_write_notread, input, 1, 1 write, 0 read.
REQ-010 SHALL have port o_bus_DV, output, 1, one-cycle response strobe, for reads and writes.
REQ-011 SHALL have port o_bus_data, output, 32, read data, right-aligned, zero-extended.
REQ-012 SHALL have port o_err, output, 1, error flag, valid with o_bus_DV.
REQ-013 SHALL have port o_busy, output, 1, high from request capture until response cycle inclusive.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESPOND; IDLE->WAIT on i_bus_DV, WAIT->RESPOND when latency counter reaches LATENCY-1, RESPOND->IDLE unconditionally.
REQ-015 SHALL capture address, data, bhw, write_notread at the edge where i_bus_DV is sampled high in IDLE.
REQ-016 SHALL assert o_bus_DV for exactly one cycle, LATENCY+1 edges after the capture edge (LATENCY=1: response visible the second cycle after request).
REQ-017 SHALL ignore i_bus_DV while not IDLE; no queueing, no state change.
REQ-018 SHALL index memory with word index i_bus_address[log2(MEM_WORDS)+1:2]; upper bits ignored (address wraps modulo memory size).
REQ-019 SHALL use little-endian lanes: byte lane = address[1:0], halfword lane = address[1].
REQ-020 SHALL on read return the selected byte/half in o_bus_data[7:0]/[15:0] with upper bits zero; word returned unchanged.
REQ-021 SHALL on write update only the addressed lanes from i_bus_data[7:0], [15:0] or [31:0]; other lanes unchanged.
REQ-022 SHALL commit the write at the response edge, so a read issued after the write response returns the new value.
REQ-023 SHALL hold o_bus_data stable from a read response until the next read response; writes leave o_bus_data unchanged.
REQ-024 SHALL leave o_bus_data zero on an errored response.

Reset
REQ-025 SHALL on i_rst_n low immediately force FSM IDLE, counter 0, o_bus_DV 0, o_bus_data 0, o_err 0, o_busy 0.
REQ-026 SHALL discard any in-flight request on reset mid-operation; a pending write SHALL NOT be committed.
REQ-027 SHALL NOT reset memory contents.

Configuration
REQ-028 SHALL provide macro BUS_MEMORY_MISALIGN_CHECK_EN.
REQ-029 With macro defined: half with address[0]=1, word with address[1:0]!=0, or bhw not in {001,010,100} SHALL respond at normal latency with o_err=1, no memory write, o_bus_data=0.
REQ-030 Without macro: o_err SHALL be constant 0; half ignores address[0], word ignores address[1:0], illegal bhw treated as word.

Verification
REQ-031 LATENCY=2: write word 0xDEADBEEF to 0x100, then read word 0x100 -> each o_bus_DV exactly 3 edges after request, read returns 0xDEADBEEF, o_err=0.
REQ-032 After REQ-031: write byte 0x55 to 0x102, read word 0x100 -> 0xDE55BEEF; read byte 0x103 -> 0x000000DE; read half 0x102 -> 0x0000DE55.
REQ-033 MEM_WORDS=4096: write word 0xA5A5A5A5 to 0x4100, read 0x100 -> 0xA5A5A5A5 (wrap).
REQ-034 Second i_bus_DV one cycle after first request -> ignored, exactly one o_bus_DV, o_busy high throughout.
REQ-035 Write word 0x12345678 to 0x200 pending, pull i_rst_n low before response -> no o_bus_DV, all outputs 0; later read 0x200 returns prior contents.
REQ-036 With BUS_MEMORY_MISALIGN_CHECK_EN: write half to 0x201 -> o_bus_DV with o_err=1, memory unchanged; without macro same access writes lanes at 0x200, o_err=0.
